// File: rtl/fifo_pack_pkg.sv
// rtl/fifo_pack_pkg.sv - shared state type and default sizes for the FIFO word packer.
package fifo_pack_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_t;

  localparam int PACK_BEATS_DEFAULT = 4;
  localparam int FIFO_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/lane_parity.sv
// rtl/lane_parity.sv - even parity (XOR reduction) of one WIDTH-bit lane.
module lane_parity #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  assign parity = ^data;

endmodule

// File: rtl/fifo_word_packer.sv
// rtl/fifo_word_packer.sv - drains a byte FIFO and packs BEATS entries into one valid/ready word.
// Per-lane even parity output exists only when PACKER_PARITY_EN is defined.
module fifo_word_packer
  import fifo_pack_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH_DEFAULT,
  parameter int BEATS = PACK_BEATS_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       fifo_data,
  input  logic                   fifo_empty,
  input  logic                   fifo_wr,
  output logic                   fifo_rd,
  input  logic                   flush,
  output logic [WIDTH*BEATS-1:0] out_data,
  output logic [BEATS-1:0]       out_keep,
  output logic                   out_valid,
  input  logic                   out_ready
`ifdef PACKER_PARITY_EN
  ,
  output logic [BEATS-1:0]       out_parity
`endif
);

  localparam int            CW   = $clog2(BEATS + 1);
  localparam logic [CW-1:0] FULL = CW'(BEATS);

  pack_state_t   state, state_nxt;
  logic [CW-1:0] issue_cnt;
  logic [CW-1:0] cap_cnt;
  logic          pend;
  logic          flush_req;
  logic          capture;
  logic          to_hold;
  logic          release_word;
  logic          flush_set;

  always_comb begin
    state_nxt    = state;
    fifo_rd      = 1'b0;
    out_valid    = 1'b0;
    capture      = 1'b0;
    to_hold      = 1'b0;
    release_word = 1'b0;
    flush_set    = 1'b0;
    case (state)
      FILL: begin
        // rst gate keeps the read request low while reset is held, whatever the inputs do
        fifo_rd   = rst && !fifo_wr && !fifo_empty && (issue_cnt < FULL) && !flush_req;
        capture   = pend;
        flush_set = flush && ((cap_cnt != '0) || pend);
        if (pend && (cap_cnt == FULL - 1'b1)) begin
          to_hold = 1'b1;
        end else if (flush_req && !pend && (cap_cnt != '0)) begin
          to_hold = 1'b1;
        end
        if (to_hold) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_valid    = 1'b1;
        release_word = out_ready;
        if (out_ready) begin
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FILL;
      issue_cnt <= '0;
      cap_cnt   <= '0;
      pend      <= 1'b0;
      flush_req <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= fifo_rd;
      if (release_word) begin
        issue_cnt <= '0;
        cap_cnt   <= '0;
      end else begin
        if (fifo_rd) begin
          issue_cnt <= issue_cnt + 1'b1;
        end
        if (capture) begin
          cap_cnt <= cap_cnt + 1'b1;
        end
      end
      if (to_hold) begin
        flush_req <= 1'b0;
      end else if (flush_set) begin
        flush_req <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < BEATS; i++) begin : g_lane
    logic [WIDTH-1:0] lane_q;
    logic             keep_q;
    logic             load;

    assign load = capture && (cap_cnt == CW'(i));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        lane_q <= '0;
        keep_q <= 1'b0;
      end else if (release_word) begin
        lane_q <= '0;
        keep_q <= 1'b0;
      end else if (load) begin
        lane_q <= fifo_data;
        keep_q <= 1'b1;
      end
    end

    assign out_data[i*WIDTH +: WIDTH] = lane_q;
    assign out_keep[i]                = keep_q;

`ifdef PACKER_PARITY_EN
    logic par_d;
    logic par_q;

    lane_parity #(.WIDTH(WIDTH)) u_parity (
      .data   (fifo_data),
      .parity (par_d)
    );

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        par_q <= 1'b0;
      end else if (release_word) begin
        par_q <= 1'b0;
      end else if (load) begin
        par_q <= par_d;
      end
    end

    assign out_parity[i] = par_q;
`endif
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb/tb_fifo_word_packer.sv - directed and randomized checks of fifo_word_packer against a queue model.
module tb_fifo_word_packer;
  import fifo_pack_pkg::*;

  localparam int W     = FIFO_WIDTH_DEFAULT;
  localparam int B     = PACK_BEATS_DEFAULT;
  localparam int DEPTH = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [W-1:0]   fifo_data;
  logic           fifo_empty;
  logic           fifo_wr = 1'b0;
  logic           fifo_rd;
  logic           flush = 1'b0;
  logic [W*B-1:0] out_data;
  logic [B-1:0]   out_keep;
  logic           out_valid;
  logic           out_ready = 1'b0;
`ifdef PACKER_PARITY_EN
  logic [B-1:0]   out_parity;
`endif

  logic [W-1:0]   wdata = '0;
  int             total = 0;
  int             bad = 0;
  bit             chk_en = 1'b0;

  always #5 clk = ~clk;

  fifo_word_packer #(.WIDTH(W), .BEATS(B)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_wr    (fifo_wr),
    .fifo_rd    (fifo_rd),
    .flush      (flush),
    .out_data   (out_data),
    .out_keep   (out_keep),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef PACKER_PARITY_EN
    ,
    .out_parity (out_parity)
`endif
  );

  // Byte FIFO in front of the packer: registered data_out, write wins over read.
  logic [W-1:0] fq[$];
  logic [W-1:0] sb[$];
  int           fcnt = 0;
  logic [W-1:0] fdout = '0;

  assign fifo_empty = (fcnt == 0);
  assign fifo_data  = fdout;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fq.delete();
      sb.delete();
      fcnt  <= 0;
      fdout <= '0;
    end else if (fifo_wr) begin
      fq.push_back(wdata);
      sb.push_back(wdata);
      fcnt <= fcnt + 1;
    end else if (fifo_rd && fcnt != 0) begin
      fdout <= fq.pop_front();
      fcnt  <= fcnt - 1;
    end
  end

  // Reference model: the word under construction is a queue of captured bytes.
  bit           m_hold;
  bit           m_pend;
  bit           m_freq;
  int           m_issued;
  logic [W-1:0] m_lanes[$];
  bit           m_rd;
  bit           m_had;
  bit           m_close;

  function automatic logic exp_rd();
    return rst && !m_hold && !fifo_wr && !fifo_empty && (m_issued < B) && !m_freq;
  endfunction

  function automatic logic [W*B-1:0] exp_data();
    logic [W*B-1:0] d = '0;
    for (int i = 0; i < m_lanes.size(); i++) d[i*W +: W] = m_lanes[i];
    return d;
  endfunction

  function automatic logic [B-1:0] exp_keep();
    return B'((1 << m_lanes.size()) - 1);
  endfunction

  function automatic logic [B-1:0] exp_parity();
    logic [B-1:0] p = '0;
    for (int i = 0; i < m_lanes.size(); i++) p[i] = ^m_lanes[i];
    return p;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_hold   = 1'b0;
      m_pend   = 1'b0;
      m_freq   = 1'b0;
      m_issued = 0;
      m_lanes.delete();
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold   = 1'b0;
        m_issued = 0;
        m_lanes.delete();
      end
    end else begin
      m_rd    = exp_rd();
      m_had   = (m_lanes.size() > 0) || m_pend;
      m_close = 1'b0;
      if (m_pend) begin
        m_lanes.push_back(fifo_data);
        m_close = (m_lanes.size() == B);
      end else if (m_freq && m_lanes.size() > 0) begin
        m_close = 1'b1;
      end
      if (m_close) begin
        m_hold = 1'b1;
        m_freq = 1'b0;
      end else if (flush && m_had) begin
        m_freq = 1'b1;
      end
      m_issued = m_issued + int'(m_rd);
      m_pend   = m_rd;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("fifo_rd", 64'(fifo_rd), 64'(exp_rd()));
      chk("out_valid", 64'(out_valid), 64'(m_hold));
      chk("out_keep", 64'(out_keep), 64'(exp_keep()));
      chk("out_data", 64'(out_data), 64'(exp_data()));
`ifdef PACKER_PARITY_EN
      chk("out_parity", 64'(out_parity), 64'(exp_parity()));
`endif
      if (out_valid && out_ready) begin
        for (int i = 0; i < B; i++) begin
          if (out_keep[i]) begin
            if (sb.size() == 0) chk("byte_order_underflow", 64'(out_data[i*W +: W]), 64'hFFFF_FFFF);
            else chk("byte_order", 64'(out_data[i*W +: W]), 64'(sb.pop_front()));
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] b);
    fifo_wr = 1'b1;
    wdata   = b;
    step();
    fifo_wr = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int maxc);
    int n = 0;
    while (!out_valid && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk({name, "_timeout"}, 64'(out_valid), 64'd1);
  endtask

  task automatic get_word(input string name, input logic [W*B-1:0] d, input logic [B-1:0] k);
    wait_valid(name, 60);
    chk({name, "_data"}, 64'(out_data), 64'(d));
    chk({name, "_keep"}, 64'(out_keep), 64'(k));
    step();
  endtask

  initial begin
    logic [W*B-1:0] w;
    logic [B-1:0]   k;
    int             rd_cnt, rd_first, rd_last, v_cnt, n;

    step();
    step();
    chk("reset_rd", 64'(fifo_rd), 64'd0);
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_keep", 64'(out_keep), 64'd0);
    chk("reset_data", 64'(out_data), 64'd0);
    rst    = 1'b1;
    chk_en = 1'b1;
    step();

    // full word with ready held high
    out_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    rd_cnt = 0; rd_first = -1; rd_last = -1; v_cnt = 0; w = '0; k = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (fifo_rd) begin
        rd_cnt++;
        if (rd_first < 0) rd_first = c;
        rd_last = c;
      end
      if (out_valid) begin
        v_cnt++;
        w = out_data;
        k = out_keep;
      end
    end
    chk("full_data", 64'(w), 64'h4433_2211);
    chk("full_keep", 64'(k), 64'hF);
    chk("full_valid_cycles", 64'(v_cnt), 64'd1);
    chk("full_rd_count", 64'(rd_cnt), 64'd4);
    chk("full_rd_span", 64'(rd_last - rd_first), 64'd3);
    step();

    // backpressure: first word held for 10 cycles, no reads while holding
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(W'(i));
    wait_valid("bp_first", 60);
    for (int c = 0; c < 10; c++) begin
      chk("bp_hold_data", 64'(out_data), 64'h0403_0201);
      chk("bp_hold_rd", 64'(fifo_rd), 64'd0);
      @(negedge clk);
    end
    step();
    out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("bp_valid_drop", 64'(out_valid), 64'd0);
    get_word("bp_second", 32'h0807_0605, 4'hF);

    // partial flush after two captures
    push(8'hA5); push(8'h5A);
    n = 0;
    while (out_keep != 4'b0011 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pf_captured", 64'(out_keep), 64'h3);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_valid("pf", 20);
    chk("pf_data", 64'(out_data), 64'h0000_5AA5);
    chk("pf_keep", 64'(out_keep), 64'h3);
`ifdef PACKER_PARITY_EN
    chk("pf_parity", 64'(out_parity), 64'h0);
`endif
    step();

    // writer collision: wr held 3 cycles while FIFO holds data
    push(8'h31); push(8'h32); push(8'h33); push(8'h34);
    step();
    for (int i = 0; i < 3; i++) begin
      fifo_wr = 1'b1;
      wdata   = W'(8'h35 + i);
      @(negedge clk);
      chk("coll_no_read", 64'(fifo_rd), 64'd0);
      step();
    end
    push(8'h38);
    get_word("coll_w1", 32'h3433_3231, 4'hF);
    get_word("coll_w2", 32'h3837_3635, 4'hF);

    // empty flush produces nothing
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("ef_no_valid", 64'(out_valid), 64'd0);
    end
    step();

    // reset after two accepted reads
    push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
    rd_cnt = 0;
    n = 0;
    while (rd_cnt < 2 && n < 20) begin
      @(negedge clk);
      if (fifo_rd) rd_cnt++;
      n++;
    end
    chk("rst_reads_seen", 64'(rd_cnt), 64'd2);
    @(posedge clk);
    #2;
    chk("pre_rst_keep", 64'(out_keep), 64'h1);
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_keep", 64'(out_keep), 64'd0);
    chk("async_rst_data", 64'(out_data), 64'd0);
    chk("async_rst_rd", 64'(fifo_rd), 64'd0);
    step();
    step();
    rst = 1'b1;
    step();
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    get_word("post_rst", 32'hC4C3_C2C1, 4'hF);

    // randomized traffic, model checks every cycle
    for (int c = 0; c < 3000; c++) begin
      fifo_wr   = (fcnt < DEPTH - 1) && ($urandom_range(2) == 0);
      wdata     = W'($urandom);
      out_ready = $urandom_range(1);
      flush     = ($urandom_range(19) == 0);
      step();
    end
    fifo_wr   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 60; c++) step();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_word_packer.md
# fifo_word_packer

Downstream consumer for the byte-wide synchronous FIFO. It drains the FIFO through the FIFO's `rd`/`empty`/`data_out` interface, packs `BEATS` consecutive entries into one wide word, and presents that word on a valid/ready stream to the next stage. A `flush` request forces out a partial word, with a lane-keep mask marking which lanes are filled.

## Interface
- `WIDTH`, 8: FIFO entry width in bits; must match the FIFO.
- `BEATS`, 4: entries packed per output word; must be at least 2.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset. The FIFO uses the same net.
- `fifo_data`  in  WIDTH: FIFO `data_out`.
- `fifo_empty`  in  1: FIFO `empty`.
- `fifo_wr`  in  1: FIFO writer's `wr`. The FIFO ignores `rd` in any cycle where `wr` is 1.
- `fifo_rd`  out  1: read request to the FIFO.
- `flush`  in  1: single-cycle pulse requesting early emission of a partial word.
- `out_data`  out  WIDTH*BEATS: packed word. Lane 0 is bits [WIDTH-1:0] and holds the oldest entry.
- `out_keep`  out  BEATS: bit i is 1 when lane i holds valid data.
- `out_valid`  out  1: word available.
- `out_ready`  in  1: consumer accepts.
- `out_parity`  out  BEATS: even parity per lane. Present only with `PACKER_PARITY_EN`.

## Operation
- State machine: FILL and HOLD.
- Accepted read: `fifo_rd && !fifo_wr && !fifo_empty` at a rising edge. Any other `fifo_rd` is a no-op and is not counted.
- Counters:
  - `issue_cnt` counts accepted reads for the current word, range 0..BEATS.
  - `cap_cnt` counts captured lanes, range 0..BEATS.
  - `pend` is 1 for the cycle after an accepted read.
- FILL:
  - `fifo_rd = !fifo_wr && !fifo_empty && issue_cnt < BEATS && !flush_req`. This is combinational from registered state and inputs.
  - When `pend` = 1: capture `fifo_data` into lane `cap_cnt`, set `out_keep[cap_cnt]`, and increment `cap_cnt`.
  - FILL -> HOLD when the capture makes `cap_cnt` equal BEATS.
  - FILL -> HOLD when `flush_req` is set, `pend` = 0 and `cap_cnt` > 0. This is the partial-word case.
- `flush_req`:
  - Set by a `flush` pulse in FILL when `cap_cnt` > 0 or `pend` = 1.
  - Cleared on entry to HOLD.
  - A `flush` pulse is ignored in HOLD, and ignored in FILL with an empty word and no read pending.
- HOLD:
  - `out_valid` = 1 and `fifo_rd` = 0.
  - `out_data`, `out_keep` and `out_parity` are stable until the handshake.
  - On `out_valid && out_ready`: return to FILL; clear `issue_cnt`, `cap_cnt`, `out_keep` and the `out_data` lanes.
- Unfilled lanes of a partial word read as zero.
- Reset clears everything:
  - `fifo_rd` = 0, `out_valid` = 0, `out_data` = 0, `out_keep` = 0, `out_parity` = 0.
  - State is FILL, all counters are 0, `pend` = 0, `flush_req` = 0.
  - A read in flight is discarded.

## Timing
- Read-to-capture latency: 1 cycle. FIFO `data_out` is registered on the accepted-read edge and sampled on the next edge.
- Back-to-back reads are sustained in FILL: one entry per cycle while the FIFO is non-empty and `fifo_wr` = 0.
- `fifo_wr` = 1 stalls reading for that cycle; no data is lost.
- Full word: `out_valid` rises 1 cycle after the edge that accepted the BEATS-th read.
- Handshake: transfer occurs on the edge where `out_valid && out_ready`. `out_valid` drops the next cycle. Reads resume in the first FILL cycle, so the minimum period per word is BEATS+2 cycles.
- `out_ready` may be held high or asserted early. It has no effect in FILL.
- Reset asserted mid-word or during HOLD: all outputs go to reset values immediately, without waiting for a clock edge.

## Configuration
- `PACKER_PARITY_EN` defined:
  - The `out_parity` port exists.
  - Bit i is the XOR of lane i, computed on capture and registered with the lane.
  - Unfilled lanes give 0.
- `PACKER_PARITY_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `fifo_pack_pkg` holds:
  - state typedef `pack_state_t {FILL, HOLD}`;
  - `PACK_BEATS_DEFAULT` = 4;
  - `FIFO_WIDTH_DEFAULT` = 8.
- One sub-module, `lane_parity` (WIDTH-bit XOR reduction), instantiated per lane only under `PACKER_PARITY_EN`.
- Counters and the FSM remain in the top module.

## Test plan
- Full word: write 0x11,0x22,0x33,0x44 into the FIFO, `out_ready`=1.
  - Required: one word with `out_data`=0x44332211 and `out_keep`=4'b1111.
  - Required: `out_valid` high for exactly 1 cycle; `fifo_rd` high for 4 consecutive cycles.
- Backpressure: 8 entries 0x01..0x08, `out_ready`=0 for 10 cycles, then 1.
  - Required: 0x04030201 held stable, no `fifo_rd` during HOLD, then 0x08070605.
- Partial flush: write 0xA5,0x5A, then pulse `flush` once both are captured.
  - Required: `out_data`=0x00005AA5 and `out_keep`=4'b0011.
  - Required with `PACKER_PARITY_EN`: `out_parity`=4'b0000.
- Writer collision: hold `fifo_wr`=1 for 3 cycles while the FIFO is non-empty.
  - Required: no accepted reads in those cycles and no duplicated or lost bytes.
  - Required: word order still oldest-first.
- Empty flush / reset: pulse `flush` with nothing captured.
  - Required: no output.
  - Then drop `rst` after 2 accepted reads. Required: `out_valid`/`out_keep`/`out_data` = 0 immediately and the next word starts at lane 0.
